// File: rtl/calc_stack_pkg.sv
// Shared types and constants for the calc_stack calculator: ALU op codes,
// controller states and the bit positions of the op-select buttons.
package calc_stack_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRA = 3'd6,
    OP_MUL = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int OP_BIT_L = 2;
  localparam int OP_BIT_C = 1;
  localparam int OP_BIT_R = 0;

endpackage

// File: rtl/calc_btn_edge.sv
// Two-flop synchroniser for an asynchronous button, followed by a
// previous-value flop so that each press yields a single-cycle event.
module calc_btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  logic sync1, sync2, prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign level = sync2;
  assign press = sync2 & ~prev;

endmodule

// File: rtl/calc_stack.sv
// Board calculator: signed accumulator with button-selected ALU ops, flags
// and a D-deep undo history. Define CALC_SAT_EN for saturating ADD/SUB/MUL.
module calc_stack
  import calc_stack_pkg::*;
#(
  parameter int W = 16,
  parameter int D = 4
) (
  input  logic                     clk,
  input  logic                     btnu,
  input  logic                     btnl,
  input  logic                     btnc,
  input  logic                     btnr,
  input  logic                     btnd,
  input  logic                     btn_undo,
  input  logic [W-1:0]             sw,
  output logic [W-1:0]             led,
  output logic                     zero,
  output logic                     ovf,
  output logic [$clog2(D+1)-1:0]   hist_cnt
);

  localparam int CW  = $clog2(D + 1);
  localparam int SHW = $clog2(W);
  localparam logic [CW-1:0] CNT_MAX = CW'(D);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic exe_level, exe_press, undo_level, undo_press;

  calc_btn_edge u_exe_edge (
    .clk   (clk),
    .rst   (btnu),
    .btn   (btnd),
    .level (exe_level),
    .press (exe_press)
  );

  calc_btn_edge u_undo_edge (
    .clk   (clk),
    .rst   (btnu),
    .btn   (btn_undo),
    .level (undo_level),
    .press (undo_press)
  );

  state_t state_q, state_d;
  logic   do_commit, do_pop;

  always_ff @(posedge clk or posedge btnu) begin
    if (btnu) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Execute beats undo when both press events land in the same cycle.
  always_comb begin
    state_d   = state_q;
    do_commit = 1'b0;
    do_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (exe_press) begin
          state_d = ST_EXEC;
        end else if (undo_press) begin
          state_d = ST_HOLD;
          do_pop  = 1'b1;
        end
      end
      ST_EXEC: begin
        state_d   = ST_HOLD;
        do_commit = 1'b1;
      end
      ST_HOLD: begin
        if (!exe_level && !undo_level) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic [W-1:0]   acc;
  logic [W-1:0]   hist [D];
  logic [2:0]     op_bits;
  op_t            op;
  logic [W:0]     add_ext, sub_ext;
  logic [2*W-1:0] prod;
  logic [W-1:0]   result;
  logic           res_ovf, true_neg;

  always_comb begin
    op_bits           = '0;
    op_bits[OP_BIT_L] = btnl;
    op_bits[OP_BIT_C] = btnc;
    op_bits[OP_BIT_R] = btnr;
    op                = op_t'(op_bits);
  end

  assign add_ext = {acc[W-1], acc} + {sw[W-1], sw};
  assign sub_ext = {acc[W-1], acc} - {sw[W-1], sw};
  assign prod    = {{W{acc[W-1]}}, acc} * {{W{sw[W-1]}}, sw};

  // A sign-extended (W+1)-bit sum overflows when its top two bits disagree.
  always_comb begin
    result   = '0;
    res_ovf  = 1'b0;
    true_neg = 1'b0;
    case (op)
      OP_ADD: begin
        result   = add_ext[W-1:0];
        res_ovf  = add_ext[W] ^ add_ext[W-1];
        true_neg = add_ext[W];
      end
      OP_SUB: begin
        result   = sub_ext[W-1:0];
        res_ovf  = sub_ext[W] ^ sub_ext[W-1];
        true_neg = sub_ext[W];
      end
      OP_AND: result = acc & sw;
      OP_OR:  result = acc | sw;
      OP_XOR: result = acc ^ sw;
      OP_SLL: result = acc << sw[SHW-1:0];
      OP_SRA: result = W'($signed(acc) >>> sw[SHW-1:0]);
      OP_MUL: begin
        result   = prod[W-1:0];
        res_ovf  = (|prod[2*W-1:W-1]) && !(&prod[2*W-1:W-1]);
        true_neg = prod[2*W-1];
      end
      default: result = '0;
    endcase
`ifdef CALC_SAT_EN
    if (res_ovf) result = true_neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
  end

  // History is a shift register: hist[0] is newest, the oldest falls off the end.
  always_ff @(posedge clk or posedge btnu) begin
    if (btnu) begin
      acc      <= '0;
      ovf      <= 1'b0;
      hist_cnt <= '0;
      for (int i = 0; i < D; i++) hist[i] <= '0;
    end else if (do_commit) begin
      for (int i = D - 1; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= acc;
      acc     <= result;
      ovf     <= res_ovf;
      if (hist_cnt != CNT_MAX) hist_cnt <= hist_cnt + CNT_ONE;
    end else if (do_pop && hist_cnt != '0) begin
      for (int i = 0; i < D - 1; i++) hist[i] <= hist[i+1];
      hist[D-1] <= '0;
      acc       <= hist[0];
      ovf       <= 1'b0;
      hist_cnt  <= hist_cnt - CNT_ONE;
    end
  end

  assign led  = acc;
  assign zero = (acc == '0);

endmodule

// File: tb/tb_calc_stack.sv
// Self-checking bench for calc_stack (W=16, D=4) using a reference model
// and a scoreboard queue; honours CALC_SAT_EN in the model as well.
module tb_calc_stack;

  localparam int W = 16;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          btnu, btnl, btnc, btnr, btnd, btn_undo;
  logic [W-1:0]  sw;
  logic [W-1:0]  led;
  logic          zero, ovf;
  logic [2:0]    hist_cnt;

  calc_stack #(.W(W), .D(D)) dut (
    .clk      (clk),
    .btnu     (btnu),
    .btnl     (btnl),
    .btnc     (btnc),
    .btnr     (btnr),
    .btnd     (btnd),
    .btn_undo (btn_undo),
    .sw       (sw),
    .led      (led),
    .zero     (zero),
    .ovf      (ovf),
    .hist_cnt (hist_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] acc;
    logic         ovf;
    logic [2:0]   cnt;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] acc_m;
  logic         ovf_m;
  logic [W-1:0] hist_m[$];
  int           tests = 0;
  int           fails = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushExpected();
    exp_t e;
    e.acc = acc_m;
    e.ovf = ovf_m;
    e.cnt = 3'(hist_m.size());
    sb.push_back(e);
  endtask

  // Reference model works on true integer values and range-checks them.
  task automatic modelExec(input logic [2:0] op, input logic [W-1:0] s);
    longint a, b, r;
    logic [W-1:0] res;
    bit arith;
    a = longint'($signed(acc_m));
    b = longint'($signed(s));
    r = 0;
    res = '0;
    arith = 0;
    case (op)
      3'd0: begin r = a + b; arith = 1; end
      3'd1: begin r = a - b; arith = 1; end
      3'd2: res = acc_m & s;
      3'd3: res = acc_m | s;
      3'd4: res = acc_m ^ s;
      3'd5: begin r = a << s[3:0]; res = r[W-1:0]; end
      3'd6: begin r = a >>> s[3:0]; res = r[W-1:0]; end
      default: begin r = a * b; arith = 1; end
    endcase
    ovf_m = 1'b0;
    if (arith) begin
      res   = r[W-1:0];
      ovf_m = (r > 32767) || (r < -32768);
`ifdef CALC_SAT_EN
      if (ovf_m) res = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
    end
    hist_m.push_front(acc_m);
    if (hist_m.size() > D) void'(hist_m.pop_back());
    acc_m = res;
    pushExpected();
  endtask

  task automatic modelUndo();
    if (hist_m.size() > 0) begin
      acc_m = hist_m.pop_front();
      ovf_m = 1'b0;
    end
    pushExpected();
  endtask

  task automatic doReset();
    btnu = 1'b1;
    tick(2);
    btnu = 1'b0;
    tick(2);
    acc_m = '0;
    ovf_m = 1'b0;
    hist_m.delete();
    sb.delete();
  endtask

  task automatic setOp(input logic [2:0] op);
    {btnl, btnc, btnr} = op;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] s, input int hold);
    setOp(op);
    sw   = s;
    btnd = 1'b1;
    modelExec(op, s);
    tick(hold);
    btnd = 1'b0;
    tick(6);
  endtask

  task automatic applyUndo(input int hold);
    btn_undo = 1'b1;
    modelUndo();
    tick(hold);
    btn_undo = 1'b0;
    tick(6);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("[TB] FAIL %s observed=no_result expected=scoreboard_entry", tag);
    end else begin
      e = sb.pop_front();
      checkVal({tag, ".led"}, 32'(led), 32'(e.acc));
      checkVal({tag, ".ovf"}, 32'(ovf), 32'(e.ovf));
      checkVal({tag, ".cnt"}, 32'(hist_cnt), 32'(e.cnt));
      checkVal({tag, ".zero"}, 32'(zero), 32'(e.acc == '0));
    end
  endtask

  initial begin
    btnu = 1'b1; btnl = 1'b0; btnc = 1'b0; btnr = 1'b0;
    btnd = 1'b0; btn_undo = 1'b0; sw = '0;
    tick(1);
    doReset();
    checkVal("reset.led", 32'(led), 32'h0);
    checkVal("reset.zero", 32'(zero), 32'h1);
    checkVal("reset.ovf", 32'(ovf), 32'h0);
    checkVal("reset.cnt", 32'(hist_cnt), 32'h0);

    // Latency: btnd first sampled at edge k, result visible after edge k+3.
    setOp(3'd0);
    sw   = 16'd5;
    btnd = 1'b1;
    modelExec(3'd0, 16'd5);
    tick(3);
    checkVal("latency.before", 32'(led), 32'h0);
    tick(1);
    checkOutput("latency.after");
    tick(1);
    btnd = 1'b0;
    tick(6);

    // Overflow at the positive limit.
    doReset();
    applyStimulus(3'd0, 16'h7FFF, 5);
    checkOutput("add_max");
    applyStimulus(3'd0, 16'h0001, 5);
    checkOutput("add_ovf");

    // Six commits then undo past the bottom of the history.
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(3'd0, 16'h0001, 5);
      checkOutput($sformatf("commit%0d", i));
    end
    for (int i = 0; i < 5; i++) begin
      applyUndo(4);
      checkOutput($sformatf("undo%0d", i));
    end

    // Long press performs a single op; simultaneous press executes only.
    applyStimulus(3'd0, 16'h0003, 50);
    checkOutput("long_press");
    setOp(3'd0);
    sw       = 16'h0010;
    btnd     = 1'b1;
    btn_undo = 1'b1;
    modelExec(3'd0, 16'h0010);
    tick(5);
    btnd     = 1'b0;
    btn_undo = 1'b0;
    tick(6);
    checkOutput("simultaneous");

    // Shift and multiply cases.
    doReset();
    applyStimulus(3'd0, 16'hFFF8, 5);
    checkOutput("load_neg8");
    applyStimulus(3'd6, 16'h0002, 5);
    checkOutput("sra");
    doReset();
    applyStimulus(3'd0, 16'd300, 5);
    checkOutput("load_300");
    applyStimulus(3'd7, 16'd300, 5);
    checkOutput("mul_ovf");

    // Mixed logic/shift/sub patterns.
    doReset();
    applyStimulus(3'd0, 16'h1234, 5);
    checkOutput("load_1234");
    applyStimulus(3'd4, 16'h00FF, 5);
    checkOutput("xor");
    applyStimulus(3'd2, 16'h0FF0, 5);
    checkOutput("and");
    applyStimulus(3'd3, 16'h8001, 5);
    checkOutput("or");
    applyStimulus(3'd5, 16'h0004, 5);
    checkOutput("sll");
    applyStimulus(3'd1, 16'h7FFF, 5);
    checkOutput("sub_ovf");
    applyStimulus(3'd1, 16'hFFFF, 5);
    checkOutput("sub");

    // Reset landing while the FSM sits in EXEC discards the operation.
    doReset();
    applyStimulus(3'd0, 16'd10, 5);
    checkOutput("pre_abort");
    setOp(3'd0);
    sw   = 16'd7;
    btnd = 1'b1;
    tick(3);
    btnu = 1'b1;
    #1;
    checkVal("abort.led", 32'(led), 32'h0);
    checkVal("abort.cnt", 32'(hist_cnt), 32'h0);
    btnd = 1'b0;
    tick(3);
    btnu = 1'b0;
    acc_m = '0;
    ovf_m = 1'b0;
    hist_m.delete();
    sb.delete();
    tick(10);
    checkVal("abort.after_led", 32'(led), 32'h0);
    checkVal("abort.after_cnt", 32'(hist_cnt), 32'h0);
    applyStimulus(3'd0, 16'd3, 5);
    checkOutput("post_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/calc_stack.md
Name: calc_stack

Overview:
- Parametrised successor of the board calculator.
- Holds a W-bit signed accumulator and applies a button-selected ALU operation with the switch operand.
- Adds button synchronisation, one-operation-per-press edge detection, overflow/zero flags, and a D-deep undo history.
- Sits between the board buttons/switches and the LED bank.

Parameters:
- W, 16, accumulator/operand/LED width (>=4).
- D, 4, undo history depth (>=1).

Ports:
- clk  in  1  system clock
- btnu  in  1  reset, asynchronous, active-high; clears all state
- btnl  in  1  op select bit 2 (level)
- btnc  in  1  op select bit 1 (level)
- btnr  in  1  op select bit 0 (level)
- btnd  in  1  execute button (asynchronous, bouncy-free assumed)
- btn_undo  in  1  undo button (asynchronous)
- sw  in  W  signed operand
- led  out  W  accumulator value
- zero  out  1  accumulator == 0
- ovf  out  1  last executed op overflowed (sticky until next execute, undo or reset)
- hist_cnt  out  $clog2(D+1)  valid undo entries, 0..D

Behaviour:
- Reset (btnu high, async):
  - acc=0, led=0, zero=1, ovf=0, hist_cnt=0.
  - Synchroniser flops cleared; FSM to IDLE.
  - Reset mid-EXEC discards the operation.
- btnd and btn_undo each pass through a 2-flop synchroniser plus a previous-value flop.
  - Press event = sync high and prev low.
- FSM states: IDLE, EXEC, HOLD.
  - IDLE + btnd event -> EXEC.
  - IDLE + undo event (no btnd event) -> HOLD, pop performed on that edge.
  - EXEC -> HOLD unconditionally; the result is written on the EXEC->HOLD edge.
  - HOLD -> IDLE when both synced buttons are low.
- Latency:
  - btnd first sampled high at edge k.
  - Event visible after edge k+1.
  - EXEC entered at edge k+2.
  - acc/led/flags update at edge k+3.
  - Undo pop updates at edge k+2.
- Op code {btnl,btnc,btnr} is sampled in EXEC:
  - 000 ADD
  - 001 SUB (acc-sw)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLL by sw[$clog2(W)-1:0]
  - 110 SRA by the same amount
  - 111 MUL (low W bits of the 2W-bit signed product)
- Overflow:
  - ADD/SUB: signed overflow.
  - MUL: product not representable in W signed bits.
  - Other ops: ovf=0.
- Commit:
  - Old acc is pushed onto history, then acc=result.
  - History full: the oldest entry is dropped (circular buffer), hist_cnt stays D.
- Undo:
  - hist_cnt>0: acc=newest entry, hist_cnt-1, ovf=0.
  - hist_cnt==0: no change.
- Simultaneous events:
  - btnd and undo events in the same cycle: btnd wins, undo ignored.
  - Any event while in EXEC/HOLD is ignored; a new press requires release first.
- zero is combinational from acc.
- led == acc at all times.

Optional Feature:
- Macro CALC_SAT_EN.
- Defined: on ADD/SUB/MUL overflow, acc saturates to 2^(W-1)-1 (positive true result) or -2^(W-1) (negative true result); ovf still set.
- Undefined: wrap-around, acc = low W bits.

Decomposition:
- Package calc_stack_pkg:
  - op enum (OP_ADD..OP_MUL, 3 bits)
  - FSM state enum (ST_IDLE, ST_EXEC, ST_HOLD)
  - op-code bit-position constants
- Sub-module calc_btn_edge: 2-flop synchroniser + edge detect, async active-high reset; instantiated for btnd and btn_undo.
- ALU is combinational inside calc_stack.

Test Plan (W=16, D=4 unless noted):
- Reset, sw=5, op 000, btnd pulse 5 cycles -> acc=5 exactly 3 edges after first sampled high; hist_cnt=1; zero=0.
- acc=0x7FFF, sw=1, ADD -> without CALC_SAT_EN acc=0x8000, ovf=1; with it acc=0x7FFF, ovf=1.
- Six commits of ADD sw=1 from 0 -> acc=6, hist_cnt=4; four undos -> 5,4,3,2; fifth undo -> acc=2, hist_cnt=0.
- btnd held high 50 cycles -> exactly one ADD performed; btnd and btn_undo rising same cycle -> execute only, hist_cnt+1.
- acc=-8, SRA with sw=2 -> acc=-2; MUL acc=300, sw=300 -> acc=0x5F90, ovf=1.
- btnu asserted between EXEC and commit edge -> acc=0, hist_cnt=0, FSM IDLE, no write after reset release.
